pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter register and instruction-fetch sequencer; the producer side of the next-address selector. It holds the current PC and drives `endAtual` (PC+4) into the selector. It accepts the selected next address `proxEnd` back from the selector and runs a request/acknowledge fetch to instruction memory. It presents each fetched instruction to the datapath with a valid/advance handshake.

## Interface
- `RESET_ADDR`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `proxEnd` in 32: next PC chosen by the selector; sampled only on an accepted advance.
- `avanca` in 1: datapath consumes the current instruction; meaningful only while `instr_valid`=1.
- `mem_ack` in 1: instruction memory returns data this cycle; single-cycle pulse.
- `mem_rdata` in 32: instruction word; valid when `mem_ack`=1.
- `pc` out 32: current PC.
- `endAtual` out 32: `pc`+4, combinational; feeds the selector's sequential input.
- `mem_req` out 1: fetch request, level.
- `mem_addr` out 32: fetch address, equal to `pc`.
- `instr` out 32: captured instruction.
- `instr_valid` out 1: `instr` is valid for the current `pc`.
- `num_busca` out 32: count of instructions consumed.
- `erro_alin` out 1: misaligned-target error, sticky.

## Operation
- States: INIT, FETCH, HOLD, ERRO.
- INIT → FETCH unconditionally on the next edge.
- FETCH:
  - `mem_req`=1.
  - On `mem_ack`=1: `instr`←`mem_rdata`, then go to HOLD.
  - Otherwise stay in FETCH; the request is held indefinitely with no timeout.
- HOLD:
  - `instr_valid`=1 and `mem_req`=0.
  - On `avanca`=1: `pc`←`proxEnd`, `num_busca`←`num_busca`+1, then go to FETCH.
  - Otherwise hold `instr` and `pc` unchanged.
- ERRO:
  - Terminal until reset.
  - `mem_req`=0, `instr_valid`=0, `erro_alin`=1.
  - `pc` frozen at the last good value.
- `mem_ack` outside FETCH is ignored. `avanca` outside HOLD is ignored.
- Arithmetic: `endAtual` = `pc`+4 modulo 2^32, so 32'hFFFF_FFFC yields 32'h0000_0000. `num_busca` wraps from 32'hFFFF_FFFF to 0.
- `proxEnd` = `pc` (self-loop) is legal and causes a refetch of the same address.

## Timing
- Reset values:
  - `pc`=RESET_ADDR, `endAtual`=RESET_ADDR+4.
  - `mem_req`=0, `instr`=0, `instr_valid`=0, `num_busca`=0, `erro_alin`=0.
  - State=INIT.
- First edge after `rst_n` rises: FETCH. `mem_req`=1 with `mem_addr`=RESET_ADDR.
- `mem_ack` at edge N: `instr_valid`=1 after edge N; `mem_req` drops after the same edge.
- `avanca` in HOLD at edge N: after edge N, `pc`=`proxEnd`, `instr_valid`=0, and `mem_req`=1.
- Minimum throughput: 2 cycles per instruction (zero-wait memory, `avanca` tied high).
- Reset asserted mid-fetch or mid-hold: all outputs go to reset values immediately, without waiting for a clock edge. A pending `mem_ack` is discarded.

## Configuration
- `PC_FETCH_ALIGN_CHECK_EN` defined:
  - An accepted advance with `proxEnd[1:0]`≠0 does not load `pc` and does not increment `num_busca`.
  - The block enters ERRO, and `erro_alin` rises after that edge.
- `PC_FETCH_ALIGN_CHECK_EN` undefined:
  - `pc` loads {`proxEnd[31:2]`,2'b00}.
  - `erro_alin` is tied to 0 and the ERRO state does not exist.

## Structure
- Shared package `processador_pkg`:
  - fetch state enum (INIT/FETCH/HOLD/ERRO)
  - constant `INSTR_BYTES`=4
  - default reset address constant
- No sub-module; the counter, PC register and FSM are one module.

## Test plan
- Reset release, memory acks on 3rd FETCH cycle with 32'h2000_0093 → `mem_addr`=0 for 3 cycles, then `instr`=32'h2000_0093, `instr_valid`=1, `endAtual`=4.
- `avanca`=1 with `proxEnd`=32'h40, zero-wait ack → `pc`=32'h40 one cycle later; `instr_valid` low one cycle; `num_busca`=1.
- `avanca` held low for 10 cycles in HOLD → `instr`, `pc` and `num_busca` unchanged; `mem_req`=0; stray `mem_ack` pulses ignored.
- `pc`=32'hFFFF_FFFC → `endAtual`=0. Advance with `proxEnd`=0 → `pc`=0.
- With macro: advance with `proxEnd`=32'h42 → ERRO, `erro_alin`=1, `pc` unchanged, no `mem_req` until reset. Without macro: `pc`=32'h40.
- `rst_n` pulsed low during FETCH → `mem_req` drops asynchronously; the next fetch is at RESET_ADDR; `num_busca`=0.

Source files
------------

// File: rtl/processador_pkg.sv
// Shared processor definitions: fetch-sequencer state encoding and address constants.
package processador_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERRO  = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES        = 4;
    localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and memory.
interface pc_fetch_if;

    // mem_req is a level held from FETCH entry until the cycle mem_ack is sampled high;
    // mem_ack is a one-cycle pulse qualifying mem_rdata and is ignored while mem_req=0.
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/pc_fetch.sv
// PC register and instruction-fetch sequencer (INIT/FETCH/HOLD/ERRO).
// Optional misaligned-target trap enabled by defining PC_FETCH_ALIGN_CHECK_EN.
module pc_fetch
    import processador_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_if.master        mem,
    input  logic [31:0]       proxEnd,
    input  logic              avanca,
    output logic [31:0]       pc,
    output logic [31:0]       endAtual,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic [31:0]       num_busca,
    output logic              erro_alin,
    output fetch_state_t      state
);

    fetch_state_t state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  instr_nxt;
    logic [31:0]  num_busca_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            pc        <= RESET_ADDR;
            instr     <= 32'h0;
            num_busca <= 32'h0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            instr     <= instr_nxt;
            num_busca <= num_busca_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        instr_nxt     = instr;
        num_busca_nxt = num_busca;
        case (state)
            INIT: state_nxt = FETCH;
            FETCH: begin
                if (mem.mem_ack) begin
                    instr_nxt = mem.mem_rdata;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (avanca) begin
`ifdef PC_FETCH_ALIGN_CHECK_EN
                    // A misaligned target keeps the last good PC and traps.
                    if (proxEnd[1:0] != 2'b00) begin
                        state_nxt = ERRO;
                    end else begin
                        pc_nxt        = proxEnd;
                        num_busca_nxt = num_busca + 32'd1;
                        state_nxt     = FETCH;
                    end
`else
                    pc_nxt        = proxEnd & ~32'(INSTR_BYTES - 1);
                    num_busca_nxt = num_busca + 32'd1;
                    state_nxt     = FETCH;
`endif
                end
            end
`ifdef PC_FETCH_ALIGN_CHECK_EN
            ERRO:    state_nxt = ERRO;
`else
            ERRO:    state_nxt = INIT;
`endif
            default: state_nxt = INIT;
        endcase
    end

    assign endAtual     = pc + 32'(INSTR_BYTES);
    assign mem.mem_req  = (state == FETCH);
    assign mem.mem_addr = pc;
    assign instr_valid  = (state == HOLD);
`ifdef PC_FETCH_ALIGN_CHECK_EN
    assign erro_alin    = (state == ERRO);
`else
    assign erro_alin    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: vector table of advances/fetches plus hand-written corner sequences.
module tb_pc_fetch;
    import processador_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [31:0]  proxEnd;
    logic         avanca;
    logic [31:0]  pc;
    logic [31:0]  endAtual;
    logic [31:0]  instr;
    logic         instr_valid;
    logic [31:0]  num_busca;
    logic         erro_alin;
    fetch_state_t state;

    pc_fetch_if mem_bus ();

    pc_fetch #(.RESET_ADDR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem         (mem_bus.master),
        .proxEnd     (proxEnd),
        .avanca      (avanca),
        .pc          (pc),
        .endAtual    (endAtual),
        .instr       (instr),
        .instr_valid (instr_valid),
        .num_busca   (num_busca),
        .erro_alin   (erro_alin),
        .state       (state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    logic [31:0] exp_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_cnt;
    logic [31:0] last_instr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    // driver tasks: inputs change on the falling edge, outputs are sampled there too
    task automatic do_fetch(input int wait_cycles, input logic [31:0] data);
        for (int i = 0; i < wait_cycles; i++) begin
            check("wait_mem_req", 32'(mem_bus.mem_req), 32'd1);
            check("wait_mem_addr", mem_bus.mem_addr, exp_pc);
            @(negedge clk);
        end
        check("ack_mem_req", 32'(mem_bus.mem_req), 32'd1);
        check("ack_mem_addr", mem_bus.mem_addr, exp_pc);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = data;
        exp_q.push_back(data);
        @(negedge clk);
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = $urandom;
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_mem_req", 32'(mem_bus.mem_req), 32'd0);
        if (exp_q.size() > 0) begin
            last_instr = exp_q.pop_front();
            check("instr", instr, last_instr);
        end
        check("endAtual", endAtual, exp_pc + 32'd4);
    endtask

    task automatic do_advance(input logic [31:0] target, input logic [31:0] new_pc);
        proxEnd = target;
        avanca  = 1'b1;
        @(negedge clk);
        avanca  = 1'b0;
        proxEnd = $urandom;
        exp_pc  = new_pc;
        exp_cnt = exp_cnt + 32'd1;
        check("adv_pc", pc, exp_pc);
        check("adv_valid", 32'(instr_valid), 32'd0);
        check("adv_mem_req", 32'(mem_bus.mem_req), 32'd1);
        check("adv_num_busca", num_busca, exp_cnt);
        check("adv_endAtual", endAtual, exp_pc + 32'd4);
    endtask

    task automatic reset_release();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        exp_pc  = 32'h0;
        exp_cnt = 32'h0;
        @(negedge clk);
        check("rr_state", 32'(state), 32'(FETCH));
        check("rr_erro_alin", 32'(erro_alin), 32'd0);
    endtask

    typedef struct {
        logic [31:0] target;
        logic [31:0] new_pc;
        int          wait_cycles;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{target: 32'h0000_0040, new_pc: 32'h0000_0040, wait_cycles: 0, rdata: 32'h0000_0013};
        vecs[1] = '{target: 32'h0000_0100, new_pc: 32'h0000_0100, wait_cycles: 1, rdata: 32'h00A0_0513};
        vecs[2] = '{target: 32'h0000_0100, new_pc: 32'h0000_0100, wait_cycles: 0, rdata: 32'hFE05_0EE3};
        vecs[3] = '{target: 32'hFFFF_FFFC, new_pc: 32'hFFFF_FFFC, wait_cycles: 2, rdata: 32'h1234_5678};
        vecs[4] = '{target: 32'h0000_0000, new_pc: 32'h0000_0000, wait_cycles: 0, rdata: 32'hDEAD_BEEF};
        vecs[5] = '{target: 32'h0000_0040, new_pc: 32'h0000_0040, wait_cycles: 3, rdata: 32'h0080_006F};

        rst_n             = 1'b0;
        avanca            = 1'b0;
        proxEnd           = 32'h0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = 32'h0;
        exp_pc            = 32'h0;
        exp_cnt           = 32'h0;
        last_instr        = 32'h0;

        // reset state
        @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_endAtual", endAtual, 32'h4);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_num_busca", num_busca, 32'h0);
        check("rst_erro_alin", 32'(erro_alin), 32'd0);
        check("rst_state", 32'(state), 32'(INIT));

        // first fetch, memory acks on the third FETCH cycle
        rst_n = 1'b1;
        @(negedge clk);
        check("first_state", 32'(state), 32'(FETCH));
        do_fetch(2, 32'h2000_0093);
        check("first_endAtual", endAtual, 32'h4);

        // vector table: advance to a target, then fetch with the given memory latency
        foreach (vecs[i]) begin
            do_advance(vecs[i].target, vecs[i].new_pc);
            do_fetch(vecs[i].wait_cycles, vecs[i].rdata);
        end

        // HOLD with avanca low for 10 cycles and stray acks
        for (int i = 0; i < 10; i++) begin
            mem_bus.mem_ack   = 1'($urandom_range(0, 1));
            mem_bus.mem_rdata = $urandom;
            @(negedge clk);
            check("idle_instr", instr, last_instr);
            check("idle_pc", pc, exp_pc);
            check("idle_num_busca", num_busca, exp_cnt);
            check("idle_mem_req", 32'(mem_bus.mem_req), 32'd0);
        end
        mem_bus.mem_ack = 1'b0;

        // wrap of endAtual at the top of the address space
        do_advance(32'hFFFF_FFFC, 32'hFFFF_FFFC);
        check("wrap_endAtual", endAtual, 32'h0);
        do_fetch(0, 32'h0000_0073);
        do_advance(32'h0000_0000, 32'h0000_0000);
        do_fetch(1, 32'h0040_0093);
        do_advance(32'h0000_0040, 32'h0000_0040);
        do_fetch(0, 32'h0000_1111);

        // misaligned advance target
`ifdef PC_FETCH_ALIGN_CHECK_EN
        proxEnd = 32'h0000_0042;
        avanca  = 1'b1;
        @(negedge clk);
        avanca  = 1'b0;
        check("mis_state", 32'(state), 32'(ERRO));
        check("mis_erro_alin", 32'(erro_alin), 32'd1);
        check("mis_pc", pc, exp_pc);
        check("mis_num_busca", num_busca, exp_cnt);
        for (int i = 0; i < 5; i++) begin
            avanca          = 1'b1;
            proxEnd         = 32'h0000_0080;
            mem_bus.mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("erro_mem_req", 32'(mem_bus.mem_req), 32'd0);
            check("erro_valid", 32'(instr_valid), 32'd0);
            check("erro_pc", pc, exp_pc);
            check("erro_sticky", 32'(erro_alin), 32'd1);
        end
        avanca          = 1'b0;
        mem_bus.mem_ack = 1'b0;
        reset_release();
        do_fetch(0, 32'h0000_2222);
`else
        do_advance(32'h0000_0042, 32'h0000_0040);
        check("mis_erro_alin", 32'(erro_alin), 32'd0);
        do_fetch(1, 32'h0000_2222);
`endif

        // asynchronous reset asserted mid-fetch with a pending ack
        do_advance(32'h0000_0080, 32'h0000_0080);
        #2;
        rst_n           = 1'b0;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 32'hBAD0_BAD0;
        #1;
        check("arst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("arst_pc", pc, 32'h0);
        check("arst_num_busca", num_busca, 32'h0);
        check("arst_instr", instr, 32'h0);
        check("arst_state", 32'(state), 32'(INIT));
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        rst_n           = 1'b1;
        exp_pc          = 32'h0;
        exp_cnt         = 32'h0;
        @(negedge clk);
        check("arst_refetch_addr", mem_bus.mem_addr, 32'h0);
        check("arst_ack_dropped", instr, 32'h0);
        do_fetch(1, 32'h0000_3333);
        do_advance(32'h0000_0004, 32'h0000_0004);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
